// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver (entrada_uart) and the
// matching transmitter (saidaUART).
//   uart_state_t : receiver FSM encoding
//   DATA_BITS    : payload bits per frame (8N1)
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/entrada_uart_if.sv
// entrada_uart_if: serial-in / parallel-out bundle of the UART receiver.
//   SerialIn   : serial line, idles high
//   Read       : one-cycle acknowledge from the consumer
//   ParalelOut : last accepted byte
//   DataReady  : level, byte waiting to be read
//   FrameError : one-cycle pulse on a bad stop bit
//   Overrun    : sticky, a frame was dropped while DataReady was high
//   Idle       : receiver is in IDLE
// slave  : receiver side
// master : line driver / consumer side
interface entrada_uart_if;
    import uart_pkg::*;

    logic                 SerialIn;
    logic                 Read;
    logic [DATA_BITS-1:0] ParalelOut;
    logic                 DataReady;
    logic                 FrameError;
    logic                 Overrun;
    logic                 Idle;

    modport slave (
        input  SerialIn, Read,
        output ParalelOut, DataReady, FrameError, Overrun, Idle
    );

    modport master (
        output SerialIn, Read,
        input  ParalelOut, DataReady, FrameError, Overrun, Idle
    );
endinterface

// File: rtl/entrada_uart_bit_timer.sv
// uart_bit_timer: bit-period cycle counter for the UART receiver.
//   clock, reset : clock, async active-high reset
//   run          : receiver is inside a frame (START/DATA/STOP)
//   load_half    : start edge seen; first strobe lands floor(N/2) edges later
//   sample       : strobe marking a bit sample point
// After each strobe the counter reloads a full bit period. With
// CLKS_PER_BIT = 1 the counter is constant 0 and sample follows run.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic load_half,
    output logic sample
);
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = CLKS_PER_BIT / 2;
    // Loaded on the start edge itself, so one less than the half period.
    localparam logic [CW-1:0] HALF_LOAD = (HALF > 0) ? CW'(HALF - 1) : '0;
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load_half)
            count <= HALF_LOAD;
        else if (!run)
            count <= '0;
        else if (count == '0)
            count <= FULL_LOAD;
        else
            count <= count - CW'(1);
    end

    assign sample = run && (count == '0);
endmodule

// File: rtl/entrada_uart.sv
// entrada_uart: 8N1 UART receiver, downstream of saidaUART.
//   clock : single clock, rising edge
//   reset : async active-high reset
//   rx    : entrada_uart_if.slave (SerialIn, Read in; ParalelOut,
//           DataReady, FrameError, Overrun, Idle out)
// Bit k of a frame (0 start, 1..8 data, 9 stop) is sampled
// k*CLKS_PER_BIT + floor(CLKS_PER_BIT/2) edges after the start edge.
module entrada_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic           clock,
    input  logic           reset,
    entrada_uart_if.slave  rx
);
    uart_state_t          state, state_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 ready_q, ready_nxt;
    logic                 overrun_q, overrun_nxt;
    logic                 ferr_q, ferr_nxt;
    logic                 load_half;
    logic                 run;
    logic                 sample;

    assign run = (state == START) || (state == DATA) || (state == STOP);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .load_half (load_half),
        .sample    (sample)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift_q   <= shift_nxt;
            data_q    <= data_nxt;
            ready_q   <= ready_nxt;
            overrun_q <= overrun_nxt;
            ferr_q    <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        data_nxt    = data_q;
        // Read acknowledges whatever is pending; acceptance below may re-set.
        ready_nxt   = ready_q & ~rx.Read;
        overrun_nxt = overrun_q & ~rx.Read;
        ferr_nxt    = 1'b0;
        load_half   = 1'b0;

        case (state)
            IDLE: begin
                if (rx.SerialIn == START_BIT) begin
                    load_half = 1'b1;
                    // At one clock per bit the start edge is the start
                    // sample, so START is skipped entirely.
                    if (CLKS_PER_BIT == 1) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 4'd1;
                    end else begin
                        state_nxt   = START;
                        bit_cnt_nxt = 4'd0;
                    end
                end
            end
            START: begin
                if (sample) begin
                    if (rx.SerialIn != START_BIT) begin
                        state_nxt   = IDLE;   // glitch, not a start bit
                        bit_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 4'd1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_nxt   = {rx.SerialIn, shift_q[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_BITS))
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    bit_cnt_nxt = 4'd0;
                    if (rx.SerialIn == STOP_BIT) begin
                        state_nxt = IDLE;
                        if (!ready_q || rx.Read) begin
                            data_nxt  = shift_q;
                            ready_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;  // consumer too slow, drop byte
                        end
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A break holds the line low; only a return to idle level
                // re-arms start detection.
                if (rx.SerialIn == STOP_BIT)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign rx.ParalelOut = data_q;
    assign rx.DataReady  = ready_q;
    assign rx.FrameError = ferr_q;
    assign rx.Overrun    = overrun_q;
    assign rx.Idle       = (state == IDLE);
endmodule

// File: tb/tb_entrada_uart.sv
// tb_entrada_uart: directed, table-driven bench for entrada_uart.
// dut1 runs at one clock per bit, dut16 at sixteen clocks per bit.
// Lines change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
module tb_entrada_uart;
    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    entrada_uart_if if1 ();
    entrada_uart_if if16 ();

    entrada_uart #(.CLKS_PER_BIT(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .rx    (if1)
    );

    entrada_uart #(.CLKS_PER_BIT(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .rx    (if16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         rd_at;     // frame bit index carrying Read, 15 = none
        logic [7:0] exp_out;
        logic       exp_rdy;
        logic       exp_ovr;
        logic       exp_ferr;
        logic       exp_idle;
    } vec_t;

    vec_t vecs[8];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 1) if1.SerialIn = b;
        else            if16.SerialIn = b;
    endtask

    // Drives one frame; returns right after the stop bit is put on the line,
    // so the stop sample of a one-clock-per-bit receiver is the next edge.
    task automatic send_frame(input int which, input logic [7:0] d, input logic stop,
                              input int rd_at, input int n);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            drive(which, bits[k]);
            if (which == 1) if1.Read = (k == rd_at);
            if (k < 9) begin
                for (int c = 1; c < n; c++) begin
                    @(negedge clock);
                    if (which == 1) if1.Read = 1'b0;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 15, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1,  2, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hC3, 1'b1,  4, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h11, 1'b1,  1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h22, 1'b1, 15, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 1'b1,  9, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h99, 1'b1, 15, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h55, 1'b0,  3, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        if1.SerialIn  = 1'b1;
        if1.Read      = 1'b0;
        if16.SerialIn = 1'b1;
        if16.Read     = 1'b0;

        // Reset state
        #12;
        chk8("rst1 out",  if1.ParalelOut, 8'h00);
        chk1("rst1 rdy",  if1.DataReady,  1'b0);
        chk1("rst1 ferr", if1.FrameError, 1'b0);
        chk1("rst1 ovr",  if1.Overrun,    1'b0);
        chk1("rst1 idle", if1.Idle,       1'b1);
        chk8("rst16 out", if16.ParalelOut, 8'h00);
        chk1("rst16 rdy", if16.DataReady,  1'b0);
        chk1("rst16 idle", if16.Idle,      1'b1);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Back-to-back frames at one clock per bit, checked at edge t0+9
        for (int i = 0; i < 8; i++) begin
            send_frame(1, vecs[i].data, vecs[i].stop, vecs[i].rd_at, 1);
            @(posedge clock);
            #1;
            chk8($sformatf("vec%0d out",  i), if1.ParalelOut, vecs[i].exp_out);
            chk1($sformatf("vec%0d rdy",  i), if1.DataReady,  vecs[i].exp_rdy);
            chk1($sformatf("vec%0d ovr",  i), if1.Overrun,    vecs[i].exp_ovr);
            chk1($sformatf("vec%0d ferr", i), if1.FrameError, vecs[i].exp_ferr);
            chk1($sformatf("vec%0d idle", i), if1.Idle,       vecs[i].exp_idle);
        end

        // Break after the bad stop bit: held low 5 more cycles, then high
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk1("break idle", if1.Idle,       1'b0);
            chk1("break ferr", if1.FrameError, 1'b0);
        end
        @(negedge clock);
        if1.SerialIn = 1'b1;
        @(posedge clock);
        #1;
        chk1("break release idle", if1.Idle, 1'b1);
        repeat (12) @(posedge clock);
        #1;
        chk1("break no frame rdy", if1.DataReady,  1'b0);
        chk8("break no frame out", if1.ParalelOut, 8'h5A);

        // Read while nothing is pending
        @(negedge clock);
        if1.Read = 1'b1;
        @(negedge clock);
        if1.Read = 1'b0;
        @(posedge clock);
        #1;
        chk1("idle read rdy", if1.DataReady, 1'b0);
        chk1("idle read ovr", if1.Overrun,   1'b0);

        // Sixteen clocks per bit: 4-cycle low glitch is a false start
        @(negedge clock);
        if16.SerialIn = 1'b0;
        @(posedge clock);
        #1;
        chk1("glitch idle falls", if16.Idle, 1'b0);
        repeat (3) @(negedge clock);
        @(negedge clock);
        if16.SerialIn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk1("glitch before sample", if16.Idle, 1'b0);
        @(posedge clock);
        #1;
        chk1("glitch back idle", if16.Idle,       1'b1);
        chk1("glitch rdy",       if16.DataReady,  1'b0);
        chk1("glitch ferr",      if16.FrameError, 1'b0);
        chk1("glitch ovr",       if16.Overrun,    1'b0);

        // Valid 0x81 frame: accepted exactly at edge t0+152
        send_frame(16, 8'h81, 1'b1, 15, 16);
        repeat (8) @(posedge clock);
        #1;
        chk1("n16 rdy at t0+151", if16.DataReady, 1'b0);
        @(posedge clock);
        #1;
        chk8("n16 out", if16.ParalelOut, 8'h81);
        chk1("n16 rdy", if16.DataReady,  1'b1);
        chk1("n16 idle", if16.Idle,      1'b1);

        // Reset in the middle of a 0xFF frame
        @(negedge clock);
        if1.SerialIn = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if1.SerialIn = 1'b1;
        end
        chk1("midframe busy", if1.Idle, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk8("midrst out",  if1.ParalelOut, 8'h00);
        chk1("midrst rdy",  if1.DataReady,  1'b0);
        chk1("midrst ferr", if1.FrameError, 1'b0);
        chk1("midrst ovr",  if1.Overrun,    1'b0);
        chk1("midrst idle", if1.Idle,       1'b1);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        send_frame(1, 8'h0F, 1'b1, 15, 1);
        @(posedge clock);
        #1;
        chk8("after rst out", if1.ParalelOut, 8'h0F);
        chk1("after rst rdy", if1.DataReady,  1'b1);
        chk1("after rst ovr", if1.Overrun,    1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/entrada_uart.md
# entrada_uart

UART receiver that sits directly downstream of the `saidaUART` transmitter. It watches the serial line and recovers 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1. Each good byte is presented on a parallel output with a level-held ready flag and a read acknowledge. Framing errors and overruns are reported.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit (≥1). A value of 1 matches the transmitter's one-bit-per-clock rate.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `SerialIn` in 1: serial line. Idles high. Synchronous to `clock` (the transmitter drives it on the falling edge).
- `Read` in 1: one-cycle acknowledge from the consumer. Clears `DataReady` and `Overrun`.
- `ParalelOut` out 8: last accepted byte, held until the next accepted byte.
- `DataReady` out 1: level. High from byte acceptance until `Read`.
- `FrameError` out 1: one-cycle pulse when the stop bit samples 0.
- `Overrun` out 1: sticky. A frame completed while `DataReady` was high; cleared by `Read`.
- `Idle` out 1: high in IDLE only.

## Operation
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- Bit sampling: let t0 be the first edge in IDLE where `SerialIn` = 0. Bit k (k=0 start, k=1..8 data, k=9 stop) is sampled at edge t0 + k·CLKS_PER_BIT + floor(CLKS_PER_BIT/2).
- IDLE, `SerialIn` = 0 → START. Bit counter cleared; cycle counter loaded for the half-bit.
- START, at the start sample point:
  - `SerialIn` = 1 → false start; go to IDLE with no flags.
  - otherwise → DATA.
- CLKS_PER_BIT = 1: the t0 sample is itself the start sample. START is traversed with no extra cycle; the next edge samples data bit 0.
- DATA: at each sample point, shift `SerialIn` into an 8-bit shift register, LSB first. After the 8th bit → STOP.
- STOP, at the stop sample point:
  - Stop = 1 and `DataReady` = 0 (or `Read` asserted this edge): load `ParalelOut`, set `DataReady` → IDLE.
  - Stop = 1 and `DataReady` = 1 with no `Read`: drop the new byte, keep `ParalelOut`, set `Overrun` → IDLE.
  - Stop = 0: discard the byte, pulse `FrameError`, `DataReady` unchanged → WAIT_HIGH.
- WAIT_HIGH: → IDLE on the first edge where `SerialIn` = 1. Break conditions are never read as a new start.
- `Read` while `DataReady` = 0: no effect.
- `Read` on the same edge as acceptance: new byte loaded, `DataReady` stays 1, `Overrun` cleared.
- Back-to-back frames (stop bit directly followed by the next start bit) must be received with no loss.

## Timing
- Reset values: `ParalelOut` = 0x00, `DataReady` = 0, `FrameError` = 0, `Overrun` = 0, `Idle` = 1, state IDLE, counters 0.
- Latency: `DataReady`/`ParalelOut`/`FrameError` update on the edge that samples the stop bit. For CLKS_PER_BIT=1 that is edge t0+9.
- `Idle` falls on edge t0 and returns high on the stop-sample edge for good frames.
- Reset mid-frame: the partial byte is lost, outputs return to reset values, the next start detection is normal.
- Cycle counter width: clog2(CLKS_PER_BIT)+1. Bit counter: 4 bits, range 0–9, no wrap beyond 9.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4)
  - DATA_BITS=8
  - frame constants START_BIT=0, STOP_BIT=1, also used by `saidaUART`.
- One natural sub-module, `uart_bit_timer`: half/full-bit cycle counter that emits a `sample` strobe. Everything else stays in `entrada_uart`.

## Test plan
- N=1, frame 0/0x A5 LSB-first/1 on `SerialIn` → `ParalelOut` = 0xA5 and `DataReady` = 1 at edge t0+9; `Idle` = 1 at the same edge.
- N=1, two back-to-back frames 0x3C then 0xC3, `Read` pulsed after the first → second byte accepted, `Overrun` = 0, final `ParalelOut` = 0xC3.
- N=1, two frames 0x11 then 0x22 with no `Read` → `ParalelOut` = 0x11, `Overrun` = 1. A `Read` then clears both `DataReady` and `Overrun`.
- N=1, frame 0x55 with stop bit 0, line held low 5 cycles then high → one-cycle `FrameError`, `DataReady` = 0, no start seen until the line goes high.
- N=16, 4-cycle low glitch then line high → false start, back to IDLE, no flags. A valid 0x81 frame then gives `ParalelOut` = 0x81 at edge t0+152.
- Reset pulsed mid-DATA on frame 0xFF → all outputs at reset values. The next frame 0x0F is received correctly.
